sonar_scheduler: RTL

//   Round-robin controller for up to NUM_SENSORS HC-SR04 ultrasonic sensors sharing one timing datapath.

---
 rtl/sonar_pkg.sv | 30 +++
 rtl/sonar_scheduler_if.sv | 32 +++
 rtl/sonar_tick_gen.sv | 27 ++
 rtl/sonar_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar scheduler and the downstream
// averaging/intensity stages.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } sonar_state_t;

  // 40 MHz clk, 0.8 us tick
  localparam int unsigned SONAR_NUM_SENSORS   = 4;
  localparam int unsigned SONAR_CLK_DIV       = 32;
  localparam int unsigned SONAR_TRIG_TICKS    = 16;
  localparam int unsigned SONAR_TIMEOUT_TICKS = 47500;
  localparam int unsigned SONAR_GUARD_TICKS   = 12500;
  localparam int unsigned SONAR_RESULT_W      = 12;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sonar_scheduler_if.sv
// Sensor pins, scan control and tagged result bus of the sonar scheduler.
// master = scheduler side, slave = sensors/consumer side.
interface sonar_scheduler_if
  import sonar_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = SONAR_NUM_SENSORS,
  parameter int unsigned RESULT_W    = SONAR_RESULT_W
);

  localparam int unsigned ID_W = id_width(NUM_SENSORS);

  logic                   enable;
  logic [NUM_SENSORS-1:0] sensor_mask;
  logic [NUM_SENSORS-1:0] echo;
  logic [NUM_SENSORS-1:0] trig;
  logic [RESULT_W-1:0]    result;
  logic [ID_W-1:0]        result_id;
  logic                   result_valid;
  logic                   result_timeout;
  logic                   busy;

  modport master (
    input  enable, sensor_mask, echo,
    output trig, result, result_id, result_valid, result_timeout, busy
  );

  modport slave (
    output enable, sensor_mask, echo,
    input  trig, result, result_id, result_valid, result_timeout, busy
  );

endinterface

// File: rtl/sonar_tick_gen.sv
// Free-running clock divider; tick is high for one clk every CLK_DIV clks.
module sonar_tick_gen #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin HC-SR04 scheduler: fires one sensor at a time, times its echo in
// ticks and publishes one tagged result per measurement.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned NUM_SENSORS   = SONAR_NUM_SENSORS,
  parameter int unsigned CLK_DIV       = SONAR_CLK_DIV,
  parameter int unsigned TRIG_TICKS    = SONAR_TRIG_TICKS,
  parameter int unsigned TIMEOUT_TICKS = SONAR_TIMEOUT_TICKS,
  parameter int unsigned GUARD_TICKS   = SONAR_GUARD_TICKS,
  parameter int unsigned RESULT_W      = SONAR_RESULT_W
) (
  input  logic             clk,
  input  logic             reset,
  sonar_scheduler_if.master bus
);

  localparam int unsigned ID_W  = id_width(NUM_SENSORS);
  localparam int unsigned CNT_W =
      $clog2(max_u(max_u(TIMEOUT_TICKS, GUARD_TICKS), TRIG_TICKS) + 1);

  localparam logic [CNT_W-1:0]    TIMEOUT_CNT = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]    TRIG_LAST   = CNT_W'(TRIG_TICKS - 1);
  localparam logic [CNT_W-1:0]    GUARD_LAST  = CNT_W'(GUARD_TICKS - 1);
  localparam logic [RESULT_W-1:0] WCNT_MAX    = '1;

  sonar_state_t           state_q;
  logic [ID_W-1:0]        cur_q;
  logic                   first_q;
  logic [CNT_W-1:0]       tcnt_q;
  logic [RESULT_W-1:0]    wcnt_q;
  logic                   seen_low_q;
  logic [NUM_SENSORS-1:0] echo_meta_q;
  logic [NUM_SENSORS-1:0] echo_s_q;
  logic [NUM_SENSORS-1:0] trig_q;
  logic [RESULT_W-1:0]    result_q;
  logic [ID_W-1:0]        result_id_q;
  logic                   result_valid_q;
  logic                   result_timeout_q;
  logic                   busy_q;

  logic            tick;
  logic            echo_cur;
  logic            tcnt_inc;
  logic            sel_found;
  logic            hi_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] any_idx;
  logic [ID_W-1:0] sel_idx;

  sonar_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign echo_cur = echo_s_q[cur_q];
  // tcnt parks at the timeout value so a late rise still times out in MEASURE
  assign tcnt_inc = tick && (tcnt_q != TIMEOUT_CNT);

  // Lowest masked index above the previous one, else wrap to the lowest overall
  always_comb begin
    sel_found = 1'b0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    any_idx   = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (bus.sensor_mask[i]) begin
        sel_found = 1'b1;
        any_idx   = ID_W'(i);
        if (first_q || (i > int'(cur_q))) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : any_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cur_q            <= '0;
      first_q          <= 1'b1;
      tcnt_q           <= '0;
      wcnt_q           <= '0;
      seen_low_q       <= 1'b0;
      echo_meta_q      <= '0;
      echo_s_q         <= '0;
      trig_q           <= '0;
      result_q         <= '0;
      result_id_q      <= '0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      echo_meta_q    <= bus.echo;
      echo_s_q       <= echo_meta_q;
      result_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.enable && |bus.sensor_mask) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (sel_found) begin
            cur_q   <= sel_idx;
            first_q <= 1'b0;
            trig_q  <= NUM_SENSORS'(1) << sel_idx;
            tcnt_q  <= '0;
            state_q <= TRIG;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        TRIG: begin
          if (tick) begin
            if (tcnt_q == TRIG_LAST) begin
              trig_q     <= '0;
              tcnt_q     <= '0;
              wcnt_q     <= '0;
              seen_low_q <= 1'b0;
              state_q    <= WAIT_RISE;
            end else begin
              tcnt_q <= tcnt_q + CNT_W'(1);
            end
          end
        end
        WAIT_RISE: begin
          if (tcnt_inc) tcnt_q <= tcnt_q + CNT_W'(1);
          if (!echo_cur) seen_low_q <= 1'b1;
          if (echo_cur && seen_low_q) begin
            // the rise clk counts as the first clk of the pulse
            wcnt_q  <= tick ? RESULT_W'(1) : '0;
            state_q <= MEASURE;
          end else if (tcnt_q == TIMEOUT_CNT) begin
            result_q         <= '0;
            result_id_q      <= cur_q;
            result_timeout_q <= 1'b1;
            result_valid_q   <= 1'b1;
            tcnt_q           <= '0;
            state_q          <= GUARD;
          end
        end
        MEASURE: begin
          if (tcnt_inc) tcnt_q <= tcnt_q + CNT_W'(1);
          if (tick && (wcnt_q != WCNT_MAX)) wcnt_q <= wcnt_q + RESULT_W'(1);
          if (!echo_cur || (tcnt_q == TIMEOUT_CNT)) begin
            result_q         <= wcnt_q;
            result_id_q      <= cur_q;
            result_timeout_q <= echo_cur;
            result_valid_q   <= 1'b1;
            tcnt_q           <= '0;
            state_q          <= GUARD;
          end
        end
        GUARD: begin
          if (tick) begin
            if (tcnt_q == GUARD_LAST) begin
              tcnt_q <= '0;
              if (bus.enable && |bus.sensor_mask) begin
                state_q <= SELECT;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tcnt_q <= tcnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig           = trig_q;
  assign bus.result         = result_q;
  assign bus.result_id      = result_id_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_timeout = result_timeout_q;
  assign bus.busy           = busy_q;

endmodule
